// File: rtl/exe_stage_pipe.sv
// exe_stage_pipe: registered execute stage with a valid/ready handshake.
// Computes operand 2, ALU result with {N,Z,C,V} and the branch target, then
// holds them in an output register until the MEM stage takes them.
// Define EXE_STAGE_MUL_EN to add the iterative shift-add multiplier (MUL state).
`timescale 1ns/1ps
module exe_stage_pipe #(
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int IMM_W      = 24,
    parameter int SHOP_W     = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic                  i_imm,
    input  logic                  i_mem_r_en,
    input  logic                  i_mem_w_en,
    input  logic                  i_wb_en,
    input  logic                  i_b,
    input  logic                  i_mul_en,
    input  logic [3:0]            i_exe_cmd,
    input  logic [3:0]            i_sr,
    input  logic [IMM_W-1:0]      i_signed_imm,
    input  logic [SHOP_W-1:0]     i_shifter_operand,
    input  logic [REG_ADDR_W-1:0] i_dest,
    input  logic [WORD_W-1:0]     i_pc,
    input  logic [WORD_W-1:0]     i_val_rn,
    input  logic [WORD_W-1:0]     i_val_rm,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic                  o_mem_r_en,
    output logic                  o_mem_w_en,
    output logic                  o_wb_en,
    output logic                  o_b,
    output logic [3:0]            o_sr,
    output logic [REG_ADDR_W-1:0] o_dest,
    output logic [WORD_W-1:0]     o_alu_res,
    output logic [WORD_W-1:0]     o_val_rm,
    output logic [WORD_W-1:0]     o_branch_addr
);

    logic              w_forMem;
    logic [4:0]        w_shAmt;
    logic [4:0]        w_rotAmt;
    logic [WORD_W-1:0] w_val2;
    logic [WORD_W-1:0] w_aluRes;
    logic [WORD_W:0]   w_sum;
    logic              w_carry;
    logic              w_ovf;
    logic [3:0]        w_aluSr;
    logic [WORD_W-1:0] w_branch;
    logic              w_slotFree;
    logic              w_accept;
    logic              w_loadAlu;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input logic [4:0] amt);
        logic [2*WORD_W-1:0] d;
        d = {v, v} >> amt;
        return d[WORD_W-1:0];
    endfunction

    assign w_forMem   = i_mem_r_en | i_mem_w_en;
    assign w_shAmt    = i_shifter_operand[11:7];
    assign w_rotAmt   = {i_shifter_operand[11:8], 1'b0};
    assign w_branch   = i_pc + {{(WORD_W-IMM_W){i_signed_imm[IMM_W-1]}}, i_signed_imm};
    assign w_slotFree = !o_out_valid | i_out_ready;
    assign w_aluSr    = {w_aluRes[WORD_W-1], (w_aluRes == '0), w_carry, w_ovf};

    // Operand 2: raw 12-bit offset for loads/stores, rotated 8-bit immediate, or shifted rm
    always_comb begin
        w_val2 = '0;
        if (w_forMem) begin
            w_val2 = WORD_W'(i_shifter_operand);
        end else if (i_imm) begin
            w_val2 = rotr(WORD_W'(i_shifter_operand[7:0]), w_rotAmt);
        end else begin
            case (i_shifter_operand[6:5])
                2'b00:   w_val2 = i_val_rm << w_shAmt;
                2'b01:   w_val2 = i_val_rm >> w_shAmt;
                2'b10:   w_val2 = $signed(i_val_rm) >>> w_shAmt;
                default: w_val2 = rotr(i_val_rm, w_shAmt);
            endcase
        end
    end

    // ALU: arithmetic ops produce ARM-style carry (not-borrow on subtract) and overflow,
    // logical ops and moves pass C and V through from the incoming status
    always_comb begin
        w_aluRes = '0;
        w_sum    = '0;
        w_carry  = i_sr[1];
        w_ovf    = i_sr[0];
        case (i_exe_cmd)
            4'b0001: w_aluRes = w_val2;
            4'b1001: w_aluRes = ~w_val2;
            4'b0010, 4'b0011: begin
                w_sum    = {1'b0, i_val_rn} + {1'b0, w_val2}
                         + (WORD_W+1)'((i_exe_cmd == 4'b0011) & i_sr[1]);
                w_aluRes = w_sum[WORD_W-1:0];
                w_carry  = w_sum[WORD_W];
                w_ovf    = (i_val_rn[WORD_W-1] == w_val2[WORD_W-1])
                         & (w_aluRes[WORD_W-1] != i_val_rn[WORD_W-1]);
            end
            4'b0100, 4'b0101: begin
                w_sum    = {1'b0, i_val_rn} + {1'b0, ~w_val2}
                         + (WORD_W+1)'((i_exe_cmd == 4'b0100) | i_sr[1]);
                w_aluRes = w_sum[WORD_W-1:0];
                w_carry  = w_sum[WORD_W];
                w_ovf    = (i_val_rn[WORD_W-1] != w_val2[WORD_W-1])
                         & (w_aluRes[WORD_W-1] != i_val_rn[WORD_W-1]);
            end
            4'b0110: w_aluRes = i_val_rn & w_val2;
            4'b0111: w_aluRes = i_val_rn | w_val2;
            4'b1000: w_aluRes = i_val_rn ^ w_val2;
            default: w_aluRes = '0;
        endcase
    end

`ifdef EXE_STAGE_MUL_EN
    localparam int CNT_W = $clog2(WORD_W);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t                r_state;
    logic [WORD_W-1:0]     r_mcand;
    logic [WORD_W-1:0]     r_mplier;
    logic [WORD_W-1:0]     r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_sMemR, r_sMemW, r_sWb, r_sB, r_sC, r_sV;
    logic [REG_ADDR_W-1:0] r_sDest;
    logic [WORD_W-1:0]     r_sValRm;
    logic [WORD_W-1:0]     r_sBranch;
    logic [WORD_W-1:0]     w_mulSum;
    logic                  w_lastBit;
    logic                  w_loadMul;
    logic                  w_unused;

    assign w_unused   = ^i_sr[3:2];
    assign w_mulSum   = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_lastBit  = (r_cnt == CNT_W'(WORD_W-1));
    assign o_in_ready = !i_rst & (r_state == S_IDLE) & w_slotFree & !i_flush;
    assign w_accept   = i_in_valid & o_in_ready;
    assign w_loadAlu  = w_accept & !i_mul_en;
    assign w_loadMul  = (r_state == S_MUL) & w_lastBit & w_slotFree;

    // Multiplier sequencer: one multiplier bit per cycle; the final bit is only
    // folded in when the output register can take the product, so a stall holds everything
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sMemR   <= 1'b0;
            r_sMemW   <= 1'b0;
            r_sWb     <= 1'b0;
            r_sB      <= 1'b0;
            r_sC      <= 1'b0;
            r_sV      <= 1'b0;
            r_sDest   <= '0;
            r_sValRm  <= '0;
            r_sBranch <= '0;
        end else if (i_flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept & i_mul_en) begin
                        r_mcand   <= i_val_rn;
                        r_mplier  <= i_val_rm;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_sMemR   <= i_mem_r_en;
                        r_sMemW   <= i_mem_w_en;
                        r_sWb     <= i_wb_en;
                        r_sB      <= i_b;
                        r_sC      <= i_sr[1];
                        r_sV      <= i_sr[0];
                        r_sDest   <= i_dest;
                        r_sValRm  <= i_val_rm;
                        r_sBranch <= w_branch;
                        r_state   <= S_MUL;
                    end
                end
                default: begin
                    if (!w_lastBit) begin
                        r_acc    <= w_mulSum;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                    end else if (w_slotFree) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end
`else
    logic w_unused;

    assign w_unused   = ^{i_sr[3:2], i_mul_en};
    assign o_in_ready = !i_rst & w_slotFree & !i_flush;
    assign w_accept   = i_in_valid & o_in_ready;
    assign w_loadAlu  = w_accept;
`endif

    // Output register: flush drops the held result, a load overwrites it, a drain without load empties it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_out_valid   <= 1'b0;
            o_mem_r_en    <= 1'b0;
            o_mem_w_en    <= 1'b0;
            o_wb_en       <= 1'b0;
            o_b           <= 1'b0;
            o_sr          <= '0;
            o_dest        <= '0;
            o_alu_res     <= '0;
            o_val_rm      <= '0;
            o_branch_addr <= '0;
        end else if (i_flush) begin
            o_out_valid <= 1'b0;
        end else if (w_loadAlu) begin
            o_out_valid   <= 1'b1;
            o_mem_r_en    <= i_mem_r_en;
            o_mem_w_en    <= i_mem_w_en;
            o_wb_en       <= i_wb_en;
            o_b           <= i_b;
            o_sr          <= w_aluSr;
            o_dest        <= i_dest;
            o_alu_res     <= w_aluRes;
            o_val_rm      <= i_val_rm;
            o_branch_addr <= w_branch;
`ifdef EXE_STAGE_MUL_EN
        end else if (w_loadMul) begin
            o_out_valid   <= 1'b1;
            o_mem_r_en    <= r_sMemR;
            o_mem_w_en    <= r_sMemW;
            o_wb_en       <= r_sWb;
            o_b           <= r_sB;
            o_sr          <= {w_mulSum[WORD_W-1], (w_mulSum == '0), r_sC, r_sV};
            o_dest        <= r_sDest;
            o_alu_res     <= w_mulSum;
            o_val_rm      <= r_sValRm;
            o_branch_addr <= r_sBranch;
`endif
        end else if (i_out_ready) begin
            o_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exe_stage_pipe.sv
// tb_exe_stage_pipe: directed and randomized bench for exe_stage_pipe with a
// queue scoreboard fed at accept time and drained by an output monitor.
`timescale 1ns/1ps
module tb_exe_stage_pipe;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] valRm;
        logic [31:0] branch;
        logic [3:0]  sr;
        logic [3:0]  dest;
        logic        memR;
        logic        memW;
        logic        wb;
        logic        b;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst, flush, inValid, inReady, imm, memR, memW, wb, bIn, mulEn;
    logic [3:0]  exeCmd, srIn, destIn;
    logic [23:0] signedImm;
    logic [11:0] shop;
    logic [31:0] pc, valRn, valRm;
    logic        outValid, outReady, memRO, memWO, wbO, bO;
    logic [3:0]  srO, destO;
    logic [31:0] aluRes, valRmO, branchAddr;

    bundle_t expQ[$];
    int      compared   = 0;
    int      mismatched = 0;
    int      transfers  = 0;

    exe_stage_pipe dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(inValid), .o_in_ready(inReady),
        .i_imm(imm), .i_mem_r_en(memR), .i_mem_w_en(memW), .i_wb_en(wb), .i_b(bIn),
        .i_mul_en(mulEn), .i_exe_cmd(exeCmd), .i_sr(srIn), .i_signed_imm(signedImm),
        .i_shifter_operand(shop), .i_dest(destIn), .i_pc(pc), .i_val_rn(valRn), .i_val_rm(valRm),
        .o_out_valid(outValid), .i_out_ready(outReady), .o_mem_r_en(memRO), .o_mem_w_en(memWO),
        .o_wb_en(wbO), .o_b(bO), .o_sr(srO), .o_dest(destO), .o_alu_res(aluRes),
        .o_val_rm(valRmO), .o_branch_addr(branchAddr)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the architectural rules
    function automatic logic [31:0] refVal2();
        logic [31:0] v;
        int          n;
        if (memR || memW) return {20'd0, shop};
        if (imm) begin
            v = {24'd0, shop[7:0]};
            n = 2 * int'(shop[11:8]);
            for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
            return v;
        end
        n = int'(shop[11:7]);
        v = valRm;
        case (shop[6:5])
            2'd0: return 32'(longint'(valRm) * (longint'(1) << n));
            2'd1: return 32'(longint'(valRm) / (longint'(1) << n));
            2'd2: for (int i = 0; i < n; i++) v = {v[31], v[31:1]};
            default: for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
        endcase
        return v;
    endfunction

    function automatic bundle_t refModel();
        bundle_t     e;
        logic [31:0] v2, r;
        logic        c, v;
        longint      u, s, k;
        longint unsigned p;
        v2 = refVal2();
        c  = srIn[1];
        v  = srIn[0];
        k  = 0;
        r  = 32'd0;
`ifdef EXE_STAGE_MUL_EN
        if (mulEn) begin
            p = longint'(valRn) * longint'(valRm);
            r = p[31:0];
        end else
`endif
        case (exeCmd)
            4'd1: r = v2;
            4'd9: r = ~v2;
            4'd6: r = valRn & v2;
            4'd7: r = valRn | v2;
            4'd8: r = valRn ^ v2;
            4'd2, 4'd3: begin
                k = (exeCmd == 4'd3 && srIn[1]) ? 1 : 0;
                u = longint'(valRn) + longint'(v2) + k;
                s = longint'($signed(valRn)) + longint'($signed(v2)) + k;
                r = u[31:0];
                c = (u > 64'sh0_FFFF_FFFF);
                v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
            end
            4'd4, 4'd5: begin
                k = (exeCmd == 4'd5 && !srIn[1]) ? 1 : 0;
                u = longint'(valRn) - longint'(v2) - k;
                s = longint'($signed(valRn)) - longint'($signed(v2)) - k;
                r = u[31:0];
                c = (u >= 0);
                v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
            end
            default: r = 32'd0;
        endcase
        e.res    = r;
        e.sr     = {r[31], r == 32'd0, c, v};
        e.valRm  = valRm;
        e.branch = 32'(longint'(pc) + longint'($signed(signedImm)));
        e.dest   = destIn;
        e.memR   = memR;
        e.memW   = memW;
        e.wb     = wb;
        e.b      = bIn;
        return e;
    endfunction

    function automatic bundle_t actualOut();
        bundle_t a;
        a = {aluRes, valRmO, branchAddr, srO, destO, memRO, memWO, wbO, bO};
        return a;
    endfunction

    task automatic checkOutput(input string name, input longint unsigned act, input longint unsigned req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkBundle(input string name, input bundle_t act, input bundle_t req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got res=%h sr=%h rm=%h br=%h dest=%h ctl=%b%b%b%b, expected res=%h sr=%h rm=%h br=%h dest=%h ctl=%b%b%b%b at %0t",
                     name, act.res, act.sr, act.valRm, act.branch, act.dest, act.memR, act.memW, act.wb, act.b,
                     req.res, req.sr, req.valRm, req.branch, req.dest, req.memR, req.memW, req.wb, req.b, $time);
        end
    endtask

    // One clock: record an accepted bundle, then drop expectations squashed by flush or reset
    task automatic stepCycle();
        logic cut;
        @(negedge clk);
        if (inValid && inReady) expQ.push_back(refModel());
        cut = flush || rst;
        @(posedge clk);
        #1;
        if (cut) expQ.delete();
    endtask

    task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                                 input logic immF, input logic [11:0] sh, input logic mulF);
        inValid = 1'b1;
        exeCmd  = cmd;
        valRn   = rn;
        valRm   = rm;
        imm     = immF;
        shop    = sh;
        mulEn   = mulF;
        memR    = 1'b0;
        memW    = 1'b0;
    endtask

    function automatic logic [31:0] randWord();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic randomStimulus();
        logic [3:0] cmds [9];
        cmds      = '{4'd1, 4'd9, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        inValid   = ($urandom_range(0, 99) < 70);
        exeCmd    = cmds[$urandom_range(0, 8)];
        valRn     = randWord();
        valRm     = randWord();
        imm       = 1'($urandom);
        shop      = 12'($urandom);
        mulEn     = ($urandom_range(0, 99) < 12);
        memR      = ($urandom_range(0, 99) < 10);
        memW      = ($urandom_range(0, 99) < 10);
        wb        = 1'($urandom);
        bIn       = 1'($urandom);
        srIn      = 4'($urandom);
        destIn    = 4'($urandom);
        pc        = $urandom;
        signedImm = 24'($urandom);
        outReady  = ($urandom_range(0, 99) < 75);
        flush     = ($urandom_range(0, 99) < 2);
    endtask

    // Monitor: pops an expectation on every transfer and checks that stalled outputs hold
    initial begin
        bundle_t cur, want, snap;
        bit      prevHold = 1'b0;
        bit      prevCut  = 1'b1;
        snap = '0;
        forever begin
            @(negedge clk);
            cur = actualOut();
            if (rst) begin
                prevHold = 1'b0;
            end else begin
                if (prevHold && !prevCut) begin
                    checkOutput("hold out_valid", outValid, 1);
                    checkBundle("hold stable", cur, snap);
                end
                if (outValid && outReady) begin
                    transfers++;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected output", 1, 0);
                    end else begin
                        want = expQ.pop_front();
                        checkBundle("result bundle", cur, want);
                    end
                end
                prevHold = outValid && !outReady;
            end
            prevCut = flush || rst;
            snap    = cur;
        end
    end

    initial begin
        int lowCnt, t0, highCnt;
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        imm = 1'b0; memR = 1'b0; memW = 1'b0; wb = 1'b0; bIn = 1'b0; mulEn = 1'b0;
        exeCmd = 4'd0; srIn = 4'd0; destIn = 4'd0; signedImm = 24'd0; shop = 12'd0;
        pc = 32'd0; valRn = 32'd0; valRm = 32'd0;

        // Reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            stepCycle();
            checkOutput("reset out_valid", outValid, 0);
            checkOutput("reset alu_res", aluRes, 0);
            checkOutput("reset in_ready", inReady, 0);
        end
        rst = 1'b0;
        #1;
        checkOutput("in_ready after reset", inReady, 1);

        // ADD rn=5 + immediate 3
        applyStimulus(4'd2, 32'd5, 32'd0, 1'b1, 12'h003, 1'b0);
        destIn = 4'd3; wb = 1'b1;
        stepCycle();
        inValid = 1'b0;
        checkOutput("add out_valid", outValid, 1);
        checkOutput("add alu_res", aluRes, 32'd8);
        checkOutput("add N,Z", srO[3:2], 0);

        // Branch target with negative offset
        applyStimulus(4'd1, 32'd0, 32'd0, 1'b1, 12'h001, 1'b0);
        pc = 32'h100; signedImm = 24'hFFFFFC; bIn = 1'b1;
        stepCycle();
        inValid = 1'b0; bIn = 1'b0;
        checkOutput("branch_addr", branchAddr, 32'hFC);

`ifdef EXE_STAGE_MUL_EN
        // MUL 7*6: in_ready low for WORD_W cycles
        applyStimulus(4'd0, 32'd7, 32'd6, 1'b0, 12'h000, 1'b1);
        stepCycle();
        inValid = 1'b0;
        lowCnt = 0;
        while (!inReady && lowCnt < 100) begin
            stepCycle();
            lowCnt++;
        end
        checkOutput("mul busy cycles", lowCnt, 32);
        checkOutput("mul 7*6 valid", outValid, 1);
        checkOutput("mul 7*6", aluRes, 32'd42);

        applyStimulus(4'd0, 32'h8000_0000, 32'd2, 1'b0, 12'h000, 1'b1);
        stepCycle();
        inValid = 1'b0;
        lowCnt = 0;
        while (!inReady && lowCnt < 100) begin
            stepCycle();
            lowCnt++;
        end
        checkOutput("mul wrap result", aluRes, 32'd0);
        checkOutput("mul wrap Z", srO[2], 1);
`endif

        // Back-pressure then back-to-back drain
        outReady = 1'b1;
        applyStimulus(4'd2, 32'd1, 32'd0, 1'b1, 12'h001, 1'b0);
        stepCycle();
        outReady = 1'b0;
        applyStimulus(4'd2, 32'd2, 32'd0, 1'b1, 12'h001, 1'b0);
        #1;
        checkOutput("backpressure in_ready", inReady, 0);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("stall in_ready", inReady, 0);
        end
        outReady = 1'b1;
        #1;
        checkOutput("release in_ready", inReady, 1);
        t0 = transfers;
        stepCycle();
        applyStimulus(4'd2, 32'd3, 32'd0, 1'b1, 12'h001, 1'b0);
        stepCycle();
        applyStimulus(4'd2, 32'd4, 32'd0, 1'b1, 12'h001, 1'b0);
        stepCycle();
        inValid = 1'b0;
        stepCycle();
        checkOutput("back-to-back transfers", transfers - t0, 4);

        // Flush a held result; a bundle offered during flush is refused
        outReady = 1'b0;
        applyStimulus(4'd2, 32'd9, 32'd0, 1'b1, 12'h001, 1'b0);
        stepCycle();
        flush = 1'b1;
        #1;
        checkOutput("in_ready during flush", inReady, 0);
        stepCycle();
        flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        #1;
        checkOutput("flush out_valid", outValid, 0);
        checkOutput("in_ready after flush", inReady, 1);

`ifdef EXE_STAGE_MUL_EN
        // Flush ten cycles into a MUL, then reset mid-MUL: neither may produce output
        applyStimulus(4'd0, 32'd11, 32'd13, 1'b0, 12'h000, 1'b1);
        stepCycle();
        inValid = 1'b0;
        for (int i = 0; i < 10; i++) stepCycle();
        flush = 1'b1;
        stepCycle();
        flush = 1'b0;
        checkOutput("mul flush in_ready", inReady, 1);
        highCnt = 0;
        for (int i = 0; i < 40; i++) begin
            stepCycle();
            if (outValid) highCnt++;
        end
        checkOutput("no stale mul after flush", highCnt, 0);

        applyStimulus(4'd0, 32'd3, 32'd5, 1'b0, 12'h000, 1'b1);
        stepCycle();
        inValid = 1'b0;
        for (int i = 0; i < 5; i++) stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        highCnt = 0;
        for (int i = 0; i < 40; i++) begin
            stepCycle();
            if (outValid) highCnt++;
        end
        checkOutput("no mul after reset", highCnt, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            randomStimulus();
            stepCycle();
        end

        // Drain everything still owed
        inValid = 1'b0; flush = 1'b0; outReady = 1'b1;
        for (int i = 0; i < 45; i++) stepCycle();
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
